// File: rtl/cla_seq_sched.sv
// cla_seq_sched: shares one 8-bit carry-lookahead slice between two
// requesters. Each WIDTH-bit addition runs one slice per cycle, and the
// carry is held in a register between slices. Results come back on one
// tagged response port.
// Optional feature macro: CLA_SEQ_SUB_EN adds per-requester subtract
// (in0 - in1) inputs that are latched at accept.

// One-bit cell: sum plus generate/propagate for the lookahead network.
module adder1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic g_o,
  output logic p_o
);
  assign g_o = a_i & b_i;
  assign p_o = a_i ^ b_i;
  assign s_o = p_o ^ c_i;
endmodule

// Four-bit carry-lookahead group. Carries are expanded in full so that no
// carry waits on a lower one. Scalar nets keep the network acyclic.
module cla4bit (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       c_i,
  output logic [3:0] s_o,
  output logic       c_o
);
  logic g0, g1, g2, g3;
  logic p0, p1, p2, p3;
  logic c1, c2, c3;

  adder1bit u_b0 (.a_i(a_i[0]), .b_i(b_i[0]), .c_i(c_i), .s_o(s_o[0]), .g_o(g0), .p_o(p0));
  adder1bit u_b1 (.a_i(a_i[1]), .b_i(b_i[1]), .c_i(c1),  .s_o(s_o[1]), .g_o(g1), .p_o(p1));
  adder1bit u_b2 (.a_i(a_i[2]), .b_i(b_i[2]), .c_i(c2),  .s_o(s_o[2]), .g_o(g2), .p_o(p2));
  adder1bit u_b3 (.a_i(a_i[3]), .b_i(b_i[3]), .c_i(c3),  .s_o(s_o[3]), .g_o(g3), .p_o(p3));

  assign c1  = g0 | (p0 & c_i);
  assign c2  = g1 | (p1 & g0) | (p1 & p0 & c_i);
  assign c3  = g2 | (p2 & g1) | (p2 & p1 & g0) | (p2 & p1 & p0 & c_i);
  assign c_o = g3 | (p3 & g2) | (p3 & p2 & g1) | (p3 & p2 & p1 & g0)
             | (p3 & p2 & p1 & p0 & c_i);
endmodule

// State table:
//   state  | meaning
//   IDLE   | arbitrate; accept one operand pair
//   ADD    | one 8-bit slice per cycle, carry chained through carry_q
//   DONE   | result held on the response port until rsp_ready
module cla_seq_sched #(
  parameter int WIDTH   = 32,
  parameter int SLICE_W = 8   // the slice hardware is two cla4bit; keep at 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_in0,
  input  logic [WIDTH-1:0] req0_in1,
  input  logic             req0_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             req0_sub,
`endif
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_in0,
  input  logic [WIDTH-1:0] req1_in1,
  input  logic             req1_cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic             req1_sub,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             rsp_id,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE_W;
  localparam int CNT_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam int IDX_W  = $clog2(WIDTH);
  localparam int SH     = $clog2(SLICE_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             id_q, id_d;
  logic             rr_q, rr_d;   // last-served requester

  logic             grant0, grant1;
  logic [WIDTH-1:0] acc_in0, acc_in1;
  logic             acc_cin;
  logic [IDX_W-1:0] base;
  logic [SLICE_W-1:0] slice_a, slice_b, slice_sum;
  logic             slice_c4, slice_cout;

  // rr_q=1 means requester 1 was served last, so requester 0 wins a tie.
  assign grant0 = req0_valid & (~req1_valid | rr_q);
  assign grant1 = req1_valid & (~req0_valid | ~rr_q);

  assign acc_in0 = grant1 ? req1_in0 : req0_in0;
`ifdef CLA_SEQ_SUB_EN
  logic acc_sub;
  logic [WIDTH-1:0] raw_in1;
  assign acc_sub = grant1 ? req1_sub : req0_sub;
  assign raw_in1 = grant1 ? req1_in1 : req0_in1;
  // Subtraction is stored as ~in1 with forced carry-in, so the slice path
  // does not need to know about the mode.
  assign acc_in1 = acc_sub ? ~raw_in1 : raw_in1;
  assign acc_cin = acc_sub | (grant1 ? req1_cin : req0_cin);
`else
  assign acc_in1 = grant1 ? req1_in1 : req0_in1;
  assign acc_cin = grant1 ? req1_cin : req0_cin;
`endif

  assign base    = IDX_W'(cnt_q) << SH;
  assign slice_a = a_q[base +: SLICE_W];
  assign slice_b = b_q[base +: SLICE_W];

  cla4bit u_lo (.a_i(slice_a[3:0]), .b_i(slice_b[3:0]), .c_i(carry_q),
                .s_o(slice_sum[3:0]), .c_o(slice_c4));
  cla4bit u_hi (.a_i(slice_a[7:4]), .b_i(slice_b[7:4]), .c_i(slice_c4),
                .s_o(slice_sum[7:4]), .c_o(slice_cout));

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_d        = a_q;
    b_d        = b_q;
    carry_d    = carry_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    id_d       = id_q;
    rr_d       = rr_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 | grant1) begin
          a_d     = acc_in0;
          b_d     = acc_in1;
          carry_d = acc_cin;
          id_d    = grant1;
          rr_d    = grant1;
          cnt_d   = '0;
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        sum_d[base +: SLICE_W] = slice_sum;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cout_d  = slice_cout;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; reset drops any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      id_q    <= 1'b0;
      rr_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      id_q    <= id_d;
      rr_q    <= rr_d;
    end
  end

  assign rsp_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign rsp_id    = id_q;

endmodule

// File: tb/tb_cla_seq_sched.sv
// Directed bench for cla_seq_sched (default WIDTH=32). The subtract vectors
// are compiled in only when CLA_SEQ_SUB_EN is defined.
module tb_cla_seq_sched;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         req0_valid = 1'b0, req1_valid = 1'b0;
  logic         req0_ready, req1_ready;
  logic [W-1:0] req0_in0 = '0, req0_in1 = '0, req1_in0 = '0, req1_in1 = '0;
  logic         req0_cin = 1'b0, req1_cin = 1'b0;
`ifdef CLA_SEQ_SUB_EN
  logic         req0_sub = 1'b0, req1_sub = 1'b0;
`endif
  logic         rsp_valid;
  logic         rsp_ready = 1'b1;
  logic [W-1:0] sum;
  logic         cout, rsp_id, busy;

  int total = 0;
  int bad   = 0;

  cla_seq_sched #(.WIDTH(W), .SLICE_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_in0(req0_in0), .req0_in1(req0_in1), .req0_cin(req0_cin),
`ifdef CLA_SEQ_SUB_EN
    .req0_sub(req0_sub),
`endif
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_in0(req1_in0), .req1_in1(req1_in1), .req1_cin(req1_cin),
`ifdef CLA_SEQ_SUB_EN
    .req1_sub(req1_sub),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .sum(sum), .cout(cout), .rsp_id(rsp_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one operation, waits (bounded) for ready, takes the accept
  // edge, then counts edges until rsp_valid. Returns sampled in DONE.
  task automatic run_op(input int port, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, output int wait_cyc, output int lat);
    wait_cyc = 0;
    if (port == 0) begin
      req0_in0 = a; req0_in1 = b; req0_cin = c; req0_valid = 1'b1;
    end else begin
      req1_in0 = a; req1_in1 = b; req1_cin = c; req1_valid = 1'b1;
    end
    #1;
    while (!((port == 0) ? req0_ready : req1_ready) && wait_cyc < 20) begin
      step();
      wait_cyc++;
    end
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   w, lat, n, viol, seen;
    logic g;

    // Reset state
    #1;
    chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
    chk("rst_busy",      64'(busy),      64'(0));
    chk("rst_sum",       64'(sum),       64'(0));
    chk("rst_cout",      64'(cout),      64'(0));
    chk("rst_rsp_id",    64'(rsp_id),    64'(0));
    chk("rst_readies",   64'({req1_ready, req0_ready}), 64'(0));
    step(); step();
    rst_n = 1'b1;
    step();

    // req0 alone: 0xFF + 1
    run_op(0, 32'h0000_00FF, 32'h0000_0001, 1'b0, w, lat);
    chk("t1_wait",    64'(w),      64'(0));
    chk("t1_latency", 64'(lat),    64'(4));
    chk("t1_sum",     64'(sum),    64'(32'h0000_0100));
    chk("t1_cout",    64'(cout),   64'(0));
    chk("t1_id",      64'(rsp_id), 64'(0));
    chk("t1_busy",    64'(busy),   64'(1));
    step();
    chk("t1_idle_busy",  64'(busy),      64'(0));
    chk("t1_idle_valid", 64'(rsp_valid), 64'(0));

    // req1, full carry chain
    run_op(1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, w, lat);
    chk("t2_latency", 64'(lat),    64'(4));
    chk("t2_sum",     64'(sum),    64'(32'h0000_0000));
    chk("t2_cout",    64'(cout),   64'(1));
    chk("t2_id",      64'(rsp_id), 64'(1));
    step();

    // Both valid continuously from reset: grants alternate starting at 0
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    req0_in0 = 32'h10;   req0_in1 = 32'h20;   req0_cin = 1'b0;
    req1_in0 = 32'h1000; req1_in1 = 32'h2000; req1_cin = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      w = 0;
      while (!(req0_ready | req1_ready) && w < 20) begin
        step();
        w++;
      end
      g = req1_ready;
      chk("t3_grant",   64'(g), 64'(i % 2));
      chk("t3_onehot",  64'(req0_ready & req1_ready), 64'(0));
      step();
      viol = 0;
      n = 0;
      while (!rsp_valid && n < 20) begin
        if (req0_ready | req1_ready) viol++;
        step();
        n++;
      end
      if (req0_ready | req1_ready) viol++;
      chk("t3_ready_busy", 64'(viol), 64'(0));
      chk("t3_latency",    64'(n),    64'(4));
      chk("t3_id",         64'(rsp_id), 64'(i % 2));
      chk("t3_sum",        64'(sum), (i % 2 == 1) ? 64'(32'h3001) : 64'(32'h30));
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();

    // Backpressure in DONE
    rsp_ready = 1'b0;
    run_op(1, 32'hAAAA_5555, 32'h1111_1111, 1'b1, w, lat);
    chk("t4_latency", 64'(lat), 64'(4));
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("t4_sum",     64'(sum),       64'(32'hBBBB_6667));
      chk("t4_cout",    64'(cout),      64'(0));
      chk("t4_id",      64'(rsp_id),    64'(1));
      chk("t4_busy",    64'(busy),      64'(1));
      chk("t4_valid",   64'(rsp_valid), 64'(1));
      chk("t4_readies", 64'({req1_ready, req0_ready}), 64'(0));
      step();
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("t4_still_done", 64'(rsp_valid), 64'(1));
    step();
    chk("t4_idle_valid", 64'(rsp_valid), 64'(0));
    chk("t4_idle_busy",  64'(busy),      64'(0));

    // Reset after two slices of 0x12345678 + 0x11111111
    req1_in0 = 32'h1234_5678; req1_in1 = 32'h1111_1111; req1_cin = 1'b0;
    req1_valid = 1'b1;
    #1;
    chk("t5_ready", 64'(req1_ready), 64'(1));
    step();
    req1_valid = 1'b0;
    step(); step();
    chk("t5_mid_busy",  64'(busy),       64'(1));
    chk("t5_mid_low16", 64'(sum[15:0]),  64'(16'h6789));
    chk("t5_mid_id",    64'(rsp_id),     64'(1));
    #3;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_sum",   64'(sum),       64'(0));
    chk("t5_rst_cout",  64'(cout),      64'(0));
    chk("t5_rst_id",    64'(rsp_id),    64'(0));
    chk("t5_rst_busy",  64'(busy),      64'(0));
    chk("t5_rst_valid", 64'(rsp_valid), 64'(0));
    step(); step();
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      if (rsp_valid) seen++;
      step();
    end
    chk("t5_no_rsp", 64'(seen), 64'(0));
    run_op(1, 32'h1234_5678, 32'h1111_1111, 1'b0, w, lat);
    chk("t5_latency", 64'(lat),    64'(4));
    chk("t5_sum",     64'(sum),    64'(32'h2345_6789));
    chk("t5_cout",    64'(cout),   64'(0));
    chk("t5_id",      64'(rsp_id), 64'(1));
    step();

`ifdef CLA_SEQ_SUB_EN
    // Subtract: 5-7 borrows, 7-5 does not; carry-in input is ignored
    req0_sub = 1'b1;
    run_op(0, 32'd5, 32'd7, 1'b0, w, lat);
    chk("sub_a_sum",  64'(sum),  64'(32'hFFFF_FFFE));
    chk("sub_a_cout", 64'(cout), 64'(0));
    step();
    run_op(0, 32'd7, 32'd5, 1'b0, w, lat);
    chk("sub_b_sum",  64'(sum),  64'(32'h0000_0002));
    chk("sub_b_cout", 64'(cout), 64'(1));
    step();
    req0_sub = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cla_seq_sched.md
# cla_seq_sched

Sequencing and arbitration controller that shares one 8-bit carry-lookahead slice between two requesters to perform WIDTH-bit additions over multiple cycles. The slice is built from the team's `cla4bit`/`adder1bit` pair. The block accepts an operand pair through a valid/ready handshake and chains carries slice-to-slice through a carry register. It presents the full-width result on a single tagged response port. It sits between the two arithmetic clients and the shared adder datapath.

## Interface
- `WIDTH`, 32: total operand width; must be an integer multiple of `SLICE_W`.
- `SLICE_W`, 8: bits processed per cycle; fixed at 8 (two chained `cla4bit`).
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0_valid` input 1: requester 0 has an operation pending.
- `req0_ready` output 1: requester 0 operation accepted on this edge when high with `req0_valid`.
- `req0_in0`, `req0_in1` input WIDTH: requester 0 operands.
- `req0_cin` input 1: requester 0 carry-in.
- `req1_valid`, `req1_ready`, `req1_in0`, `req1_in1`, `req1_cin`: same as requester 0, for requester 1.
- `rsp_valid` output 1: result available.
- `rsp_ready` input 1: consumer takes the result.
- `sum` output WIDTH: result.
- `cout` output 1: carry out of the MSB slice.
- `rsp_id` output 1: index of the requester that issued the result.
- `busy` output 1: high in ADD and DONE.

## Operation
- FSM states:
  - IDLE: the arbiter grants one valid requester. `reqN_ready` = (state==IDLE) & grant==N. On handshake, latch in0, in1, and the carry register ← cin. Set `rsp_id` ← N and cnt ← 0, then go to ADD.
  - ADD: compute one slice per cycle. The slice adds `in0[cnt*8 +: 8]`, `in1[cnt*8 +: 8]`, and the carry register. On each edge, write `sum[cnt*8 +: 8]`, set the carry register ← slice cout, and cnt++. On the edge where cnt==NSLICE-1, write `cout` and go to DONE.
  - DONE: hold `rsp_valid`=1. On `rsp_valid & rsp_ready`, go to IDLE.
- NSLICE = WIDTH/SLICE_W; cnt is $clog2(NSLICE) bits wide and wraps only through the IDLE reload.
- Arbitration is round-robin with a 1-bit pointer to the last-served requester.
  - If only one requester is valid, it is granted.
  - If both are valid, the requester that is not last-served wins.
  - The pointer updates only on an accept handshake.
- Requesters must hold valid and operands stable until ready. `reqN_ready` depends combinationally on the other port's valid; it has no path from `rsp_ready`.
- Operands are latched at accept; input changes after the handshake have no effect.
- Result modulo 2^WIDTH. {cout,sum} equals in0+in1+cin exactly (in add mode).
- Reset values:
  - All outputs 0, state IDLE, cnt 0.
  - Carry register 0.
  - RR pointer = 1, so requester 0 wins the first contention.
- Reset asserted mid-ADD or in DONE: the partial result is discarded. Outputs clear immediately, asynchronously, and no response is issued for that operation.

## Timing
- Accept on edge E0. Slices are computed on edges E1..E_NSLICE. `rsp_valid` rises after E_NSLICE, so latency is NSLICE cycles (4 at defaults).
- `sum`/`cout`/`rsp_id` are stable while `rsp_valid`=1 and until the next accept. Upper slices show old data during ADD, which consumers must ignore.
- DONE→IDLE on the handshake edge. The next accept occurs no earlier than the following edge, giving a minimum issue interval of NSLICE+2 cycles.
- No accept is possible during ADD or DONE: both readies are 0.
- `rsp_ready` held low keeps the block in DONE indefinitely, and all response outputs hold.

## Configuration
- `CLA_SEQ_SUB_EN` defined:
  - Adds `req0_sub` and `req1_sub` inputs (1 bit each), latched at accept.
  - When sub=1, the slice uses ~in1 and the carry-in is forced to 1 (`reqN_cin` is ignored), giving in0−in1. `cout`=1 means no borrow.
- Undefined: the sub ports are absent and the block is add-only.

## Test plan
- req0 only: in0=0x000000FF, in1=0x00000001, cin=0 → `rsp_valid` 4 cycles after accept; sum=0x00000100, cout=0, rsp_id=0.
- Full carry chain: req1, in0=0xFFFFFFFF, in1=0, cin=1 → sum=0x00000000, cout=1, rsp_id=1.
- Both valid continuously from reset, three operations each → grant order 0,1,0,1,0,1. `reqN_ready` is never high during ADD or DONE.
- Backpressure: `rsp_ready`=0 for 5 cycles in DONE → sum, cout and rsp_id stable, busy=1, both readies 0. Then `rsp_ready`=1 → IDLE on the next edge.
- `rst_n` pulsed low after 2 slices of 0x12345678+0x11111111 → immediate zero outputs and no response. Then 0x12345678+0x11111111 → 0x23456789.
- With `CLA_SEQ_SUB_EN`: 5−7 → sum=0xFFFFFFFE, cout=0; 7−5 → sum=0x00000002, cout=1.
